// File: rtl/counter_drv_pkg.sv
// Shared types and defaults for the counter driver and its shadow model.
package counter_drv_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int LEN_W_DEF = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Reserved encoding 2'b00 behaves like OP_UP.
  typedef enum logic [1:0] {
    OP_RSVD = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/counter_model.sv
// Shadow of the driven up/down counter, fed by the same registered controls
// so its value always matches what a healthy counter should hold.
module counter_model
  import counter_drv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             updown,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] exp
);

  logic [WIDTH-1:0] exp_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_reg <= '0;
    end else if (load) begin
      exp_reg <= data;
    end else if (updown) begin
      exp_reg <= exp_reg + 1'b1;
    end else begin
      exp_reg <= exp_reg - 1'b1;
    end
  end

  assign exp = exp_reg;

endmodule

// File: rtl/counter_driver.sv
// Turns LOAD/UP/DOWN commands into counter control cycles, then samples the
// counter and reports whether it agrees with the shadow model.
module counter_driver
  import counter_drv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             ctr_load,
  output logic             ctr_updown,
  output logic [WIDTH-1:0] ctr_data,
  input  logic [WIDTH-1:0] ctr_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_count,
  output logic             rsp_err,
  output logic [7:0]       err_cnt
);

  state_e           state_reg, state_next;
  logic [LEN_W-1:0] rem_reg, rem_next;
  logic             ctr_load_reg, ctr_load_next;
  logic             ctr_updown_reg, ctr_updown_next;
  logic [WIDTH-1:0] ctr_data_reg, ctr_data_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [WIDTH-1:0] rsp_count_reg, rsp_count_next;
  logic             rsp_err_reg, rsp_err_next;
  logic [7:0]       err_cnt_reg, err_cnt_next;

  logic [WIDTH-1:0] exp_val;
  logic             mismatch;
  op_e              op_in;

  assign op_in    = op_e'(cmd_op);
  assign mismatch = (ctr_count != exp_val);

  // The shadow sees exactly the registered controls the real counter sees.
  counter_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .clk    (clk),
    .rst    (rst),
    .load   (ctr_load_reg),
    .updown (ctr_updown_reg),
    .data   (ctr_data_reg),
    .exp    (exp_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      rem_reg        <= '0;
      ctr_load_reg   <= 1'b0;
      ctr_updown_reg <= 1'b1;
      ctr_data_reg   <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_count_reg  <= '0;
      rsp_err_reg    <= 1'b0;
      err_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      rem_reg        <= rem_next;
      ctr_load_reg   <= ctr_load_next;
      ctr_updown_reg <= ctr_updown_next;
      ctr_data_reg   <= ctr_data_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_count_reg  <= rsp_count_next;
      rsp_err_reg    <= rsp_err_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rem_next        = rem_reg;
    ctr_load_next   = ctr_load_reg;
    ctr_updown_next = ctr_updown_reg;
    ctr_data_next   = ctr_data_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_count_next  = rsp_count_reg;
    rsp_err_next    = rsp_err_reg;
    err_cnt_next    = err_cnt_reg;

    case (state_reg)
      IDLE: begin
        ctr_load_next = 1'b0;
        if (cmd_valid) begin
          state_next = DRIVE;
          // Controls are registered here so the first drive cycle follows accept.
          case (op_in)
            OP_LOAD: begin
              rem_next      = LEN_W'(1);
              ctr_load_next = 1'b1;
              ctr_data_next = cmd_data;
            end
            OP_DOWN: begin
              rem_next        = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
              ctr_updown_next = 1'b0;
            end
            default: begin
              rem_next        = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
              ctr_updown_next = 1'b1;
            end
          endcase
        end
      end

      DRIVE: begin
        if (rem_reg == LEN_W'(1)) begin
          state_next    = CHECK;
          ctr_load_next = 1'b0;
        end else begin
          rem_next = rem_reg - 1'b1;
        end
      end

      CHECK: begin
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        rsp_count_next = ctr_count;
        rsp_err_next   = mismatch;
        if (mismatch && (err_cnt_reg != ERR_CNT_MAX)) begin
          err_cnt_next = err_cnt_reg + 8'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cmd_ready  = (state_reg == IDLE);
  assign ctr_load   = ctr_load_reg;
  assign ctr_updown = ctr_updown_reg;
  assign ctr_data   = ctr_data_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_count  = rsp_count_reg;
  assign rsp_err    = rsp_err_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_counter_driver.sv
// Bench for counter_driver: a free-running counter is attached to the driver,
// a timeline-based reference predicts every output, and directed commands pin
// hand-computed results.
module tb_counter_driver;

  localparam int W  = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [W-1:0]  cmd_data = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          ctr_load;
  logic          ctr_updown;
  logic [W-1:0]  ctr_data;
  logic [W-1:0]  ctr_count;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_count;
  logic          rsp_err;
  logic [7:0]    err_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  counter_driver #(
    .WIDTH(W),
    .LEN_W(LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_len    (cmd_len),
    .ctr_load   (ctr_load),
    .ctr_updown (ctr_updown),
    .ctr_data   (ctr_data),
    .ctr_count  (ctr_count),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_count  (rsp_count),
    .rsp_err    (rsp_err),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
  endtask

  // The real counter under drive; 'stuck' models a broken counter frozen at 7.
  logic [W-1:0] phys = '0;
  bit           stuck = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst)           phys <= '0;
    else if (stuck)     phys <= W'(7);
    else if (ctr_load)  phys <= ctr_data;
    else if (ctr_updown) phys <= phys + 1'b1;
    else                phys <= phys - 1'b1;
  end
  assign ctr_count = phys;

  // Reference: a command accepted at edge t with length n drives on edges
  // t+1..t+n, is sampled on edge t+n+1, and responds until the handshake edge.
  bit           m_busy = 1'b0;
  int           cyc = 0;
  int           t_acc = 0;
  int           m_n = 0;
  bit           m_isload = 1'b0;
  bit           m_up = 1'b1;
  logic [W-1:0] m_data = '0;
  logic         e_load = 1'b0;
  logic         e_ud = 1'b1;
  logic [W-1:0] e_data = '0;
  logic [W-1:0] ideal = '0;
  logic [W-1:0] ideal_nxt;
  logic         e_rsp_valid = 1'b0;
  logic [W-1:0] e_rsp_count = '0;
  logic         e_rsp_err = 1'b0;
  int           e_err_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; cyc = 0; e_load = 1'b0; e_ud = 1'b1; e_data = '0; ideal = '0;
      e_rsp_valid = 1'b0; e_rsp_count = '0; e_rsp_err = 1'b0; e_err_cnt = 0;
    end else begin
      ideal_nxt = e_load ? e_data : (e_ud ? ideal + 1'b1 : ideal - 1'b1);
      if (m_busy && cyc == t_acc + m_n + 1) begin
        e_rsp_count = ctr_count;
        e_rsp_err   = (ctr_count != ideal);
        if (e_rsp_err && e_err_cnt < 255) e_err_cnt++;
      end else if (m_busy && cyc >= t_acc + m_n + 2 && rsp_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy && cmd_valid) begin
        m_busy   = 1'b1;
        t_acc    = cyc;
        m_isload = (cmd_op == 2'b01);
        m_up     = (cmd_op != 2'b11);
        m_data   = cmd_data;
        m_n      = m_isload ? 1 : ((cmd_len == 0) ? 1 : int'(cmd_len));
      end
      ideal = ideal_nxt;
      if (m_busy && cyc >= t_acc && cyc <= t_acc + m_n - 1) begin
        e_load = m_isload;
        if (m_isload) e_data = m_data;
        else          e_ud   = m_up;
      end else begin
        e_load = 1'b0;
      end
      e_rsp_valid = m_busy && (cyc >= t_acc + m_n + 1);
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("ctr_load", ctr_load, e_load);
      chk("ctr_updown", ctr_updown, e_ud);
      if (e_load) chk("ctr_data", ctr_data, e_data);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid) begin
        chk("rsp_count", rsp_count, e_rsp_count);
        chk("rsp_err", rsp_err, e_rsp_err);
      end
      chk("err_cnt", err_cnt, e_err_cnt);
    end
  end

  // Issue one command (called just after a rising edge), wait for its
  // response, optionally hold off rsp_ready for 'hold' cycles, then consume it.
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] d, input logic [LW-1:0] l,
                        input int hold, input logic [W-1:0] hold_exp,
                        output logic [W-1:0] cnt, output logic err, output int lat);
    int k;
    cnt = '0; err = 1'b0; lat = 0; k = 0;
    cmd_op = op; cmd_data = d; cmd_len = l; cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      rsp_ready = 1'b1;
      return;
    end
    cnt = rsp_count; err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = ~d;
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_count", rsp_count, hold_exp);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    $display("cmd op=%0d data=%0d len=%0d -> count=%0d err=%0d lat=%0d err_cnt=%0d",
             op, d, l, cnt, err, lat, err_cnt);
  endtask

  initial begin
    logic [W-1:0] c;
    logic         e;
    int           lat;

    #2 rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ctr_load", ctr_load, 0);
    chk("rst_ctr_updown", ctr_updown, 1);
    chk("rst_ctr_data", ctr_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_count", rsp_count, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back commands; the counter free-runs up between them.
    do_cmd(2'b01, 4'd5, 8'd0, 0, 4'd0, c, e, lat);
    chk("load5_count", c, 5); chk("load5_err", e, 0); chk("load5_lat", lat, 2);
    do_cmd(2'b01, 4'd14, 8'd0, 0, 4'd0, c, e, lat);
    chk("load14_count", c, 14);
    // 14 plus 3 idle-phase ups before accept plus 3 driven ups: 20 mod 16.
    do_cmd(2'b10, 4'd0, 8'd3, 0, 4'd0, c, e, lat);
    chk("up3_count", c, 4); chk("up3_err", e, 0); chk("up3_lat", lat, 4);
    do_cmd(2'b01, 4'd1, 8'd0, 0, 4'd0, c, e, lat);
    chk("load1_count", c, 1);
    // 1 then 3 free-run ups to 4, one driven down: 3.
    do_cmd(2'b11, 4'd0, 8'd0, 0, 4'd0, c, e, lat);
    chk("down0_count", c, 3); chk("down0_err", e, 0); chk("down0_lat", lat, 2);
    // Counter reaches 0 at accept, two downs wrap to 15 then 14.
    do_cmd(2'b11, 4'd0, 8'd2, 0, 4'd0, c, e, lat);
    chk("down2_wrap_count", c, 14); chk("down2_err", e, 0);
    // Downs continue to 11 at accept; reserved op counts up twice.
    do_cmd(2'b00, 4'd0, 8'd2, 0, 4'd0, c, e, lat);
    chk("rsvd_up_count", c, 13); chk("rsvd_err", e, 0);

    do_cmd(2'b01, 4'd9, 8'd0, 5, 4'd9, c, e, lat);
    chk("hold_load9_count", c, 9);
    chk("err_cnt_clean", err_cnt, 0);

    // Broken counter: every check mismatches until err_cnt saturates.
    stuck = 1'b1;
    do_cmd(2'b01, 4'd3, 8'd0, 0, 4'd0, c, e, lat);
    chk("stuck_count", c, 7); chk("stuck_err", e, 1); chk("stuck_err_cnt1", err_cnt, 1);
    for (int i = 1; i < 300; i++) do_cmd(2'b01, 4'd3, 8'd0, 0, 4'd0, c, e, lat);
    chk("err_cnt_sat", err_cnt, 255);

    // Reset mid-DRIVE aborts the command.
    stuck = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    cmd_op = 2'b11; cmd_len = 8'd10; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("drive_updown", ctr_updown, 0);
    rst = 1'b0;
    #1;
    chk("abort_ctr_load", ctr_load, 0);
    chk("abort_ctr_updown", ctr_updown, 1);
    chk("abort_ctr_data", ctr_data, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_count", rsp_count, 0);
    chk("abort_rsp_err", rsp_err, 0);
    chk("abort_err_cnt", err_cnt, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
